// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between producers, the write arbiter and the FIFO flags.
// master = arbiter side, slave = producers/FIFO side.
interface fifo_wr_arbiter_if #(
   parameter int FIFO_WIDTH = 16,
   parameter int NUM_REQ    = 4,
   parameter int OW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
   logic [NUM_REQ-1:0]            req;
   logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            gnt;
   logic                          fifo_wr_en;
   logic [FIFO_WIDTH-1:0]         fifo_data_in;
   logic                          fifo_full;
   logic                          fifo_almostfull;
   logic                          fifo_overflow;
   logic [OW-1:0]                 owner;
   logic                          busy;

   modport master (
      input  req, req_data, fifo_full, fifo_almostfull, fifo_overflow,
      output gnt, fifo_wr_en, fifo_data_in, owner, busy
   );

   modport slave (
      output req, req_data, fifo_full, fifo_almostfull, fifo_overflow,
      input  gnt, fifo_wr_en, fifo_data_in, owner, busy
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers.
// Optional statistics counters are compiled in with FIFO_WR_ARB_STATS_EN.
//
//   state   | meaning
//   S_IDLE  | no owner; pick next requester round-robin (no grant this cycle)
//   S_BURST | owner streams beats until MAX_BURST, req drop, stalls on space
module fifo_wr_arbiter #(
   parameter int FIFO_WIDTH = 16,
   parameter int NUM_REQ    = 4,
   parameter int MAX_BURST  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   fifo_wr_arbiter_if.master     bus
`ifdef FIFO_WR_ARB_STATS_EN
   ,
   output logic [15:0]           wr_cnt,
   output logic                  ovf_err,
   output logic [NUM_REQ*16-1:0] gnt_cnt
`endif
);
   localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int BW = $clog2(MAX_BURST) + 1;
   localparam logic [OW-1:0] LAST_RST  = OW'(NUM_REQ - 1);
   localparam logic [BW-1:0] BEAT_LAST = BW'(MAX_BURST - 1);

   typedef enum logic {S_IDLE, S_BURST} state_t;

   state_t                state_q, state_d;
   logic [OW-1:0]         owner_q, owner_d;
   logic [OW-1:0]         last_q, last_d;
   logic [BW-1:0]         beat_cnt_q, beat_cnt_d;
   logic                  wr_en_q, wr_en_d;
   logic [FIFO_WIDTH-1:0] data_q, data_d;
   logic [NUM_REQ-1:0]    gnt_c;
   logic [OW-1:0]         rr_sel;
   logic                  space_ok;
   logic                  grant;

   // The registered write still in flight may consume the last free slot.
   assign space_ok = !bus.fifo_full && !(bus.fifo_almostfull && wr_en_q);

   always_comb begin
      rr_sel = last_q;
      for (int k = NUM_REQ; k >= 1; k--) begin
         if (bus.req[(int'(last_q) + k) % NUM_REQ])
            rr_sel = OW'((int'(last_q) + k) % NUM_REQ);
      end
   end

   always_comb begin
      gnt_c = '0;
      grant = 1'b0;
      if (rst_n && state_q == S_BURST && bus.req[owner_q] && space_ok) begin
         gnt_c[owner_q] = 1'b1;
         grant          = 1'b1;
      end
   end

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      last_d     = last_q;
      beat_cnt_d = beat_cnt_q;
      wr_en_d    = 1'b0;
      data_d     = data_q;
      case (state_q)
         S_IDLE: begin
            if (|bus.req) begin
               owner_d    = rr_sel;
               beat_cnt_d = '0;
               state_d    = S_BURST;
            end
         end
         S_BURST: begin
            if (grant) begin
               wr_en_d    = 1'b1;
               data_d     = bus.req_data[int'(owner_q)*FIFO_WIDTH +: FIFO_WIDTH];
               beat_cnt_d = beat_cnt_q + 1'b1;
               if (beat_cnt_q == BEAT_LAST) begin
                  last_d  = owner_q;
                  state_d = S_IDLE;
               end
            end else if (!bus.req[owner_q]) begin
               last_d  = owner_q;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         owner_q    <= '0;
         last_q     <= LAST_RST;
         beat_cnt_q <= '0;
         wr_en_q    <= 1'b0;
         data_q     <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         last_q     <= last_d;
         beat_cnt_q <= beat_cnt_d;
         wr_en_q    <= wr_en_d;
         data_q     <= data_d;
      end
   end

   assign bus.gnt          = gnt_c;
   assign bus.fifo_wr_en   = wr_en_q;
   assign bus.fifo_data_in = data_q;
   assign bus.owner        = owner_q;
   assign bus.busy         = (state_q == S_BURST);

`ifdef FIFO_WR_ARB_STATS_EN
   logic [15:0] wr_cnt_q;
   logic        ovf_err_q;
   logic [15:0] gnt_cnt_q [NUM_REQ];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_cnt_q  <= '0;
         ovf_err_q <= 1'b0;
         for (int i = 0; i < NUM_REQ; i++) gnt_cnt_q[i] <= '0;
      end else begin
         if (wr_en_q && wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
         if (bus.fifo_overflow) ovf_err_q <= 1'b1;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_c[i] && gnt_cnt_q[i] != 16'hFFFF)
               gnt_cnt_q[i] <= gnt_cnt_q[i] + 16'd1;
         end
      end
   end

   always_comb begin
      gnt_cnt = '0;
      for (int i = 0; i < NUM_REQ; i++) gnt_cnt[i*16 +: 16] = gnt_cnt_q[i];
   end

   assign wr_cnt  = wr_cnt_q;
   assign ovf_err = ovf_err_q;
`else
   logic unused_ovf;
   assign unused_ovf = bus.fifo_overflow;
`endif
endmodule
